// File: rtl/zigzag_reorder_pkg.sv
// Shared JPEG constants: block geometry and the zigzag-to-natural index table.
package zigzag_reorder_pkg;

    localparam int unsigned BLOCK_ROWS = 8;
    localparam int unsigned ROW_W      = 3;
    localparam int unsigned IDX_W      = 6;

    localparam logic [IDX_W-1:0] ZZ_TO_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    function automatic logic [IDX_W-1:0] zz_nat(input logic [IDX_W-1:0] zz_idx);
        return ZZ_TO_NAT[zz_idx];
    endfunction

endpackage

// File: rtl/zigzag_reorder.sv
// Row-in, zigzag-out reorder of 8x8 coefficient blocks through a two-entry ping-pong store.
module zigzag_reorder
    import zigzag_reorder_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [BLOCK_ROWS*W-1:0] in_data,
    input  logic                    in_sob,
    input  logic                    in_eob,
    input  logic                    in_sof,
    output logic                    out_valid,
    output logic [BLOCK_ROWS*W-1:0] out_data,
    output logic                    out_sob,
    output logic                    out_eob,
    output logic                    out_sof,
    output logic                    err_framing
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BLOCK_ROWS - 1);

    logic [W-1:0]            store [2][BLOCK_ROWS][BLOCK_ROWS];
    logic [1:0]              full;
    logic [1:0]              sof_tag;
    logic                    wr_sel;
    logic                    rd_sel;
    logic [ROW_W-1:0]        wr_row;
    logic [ROW_W-1:0]        rd_beat;
    logic [ROW_W-1:0]        row_c;
    logic                    wr_en_c;
    logic [IDX_W-1:0]        nat_c [BLOCK_ROWS];
    logic [BLOCK_ROWS*W-1:0] zz_beat_c;

    // A start-of-block beat always lands in row 0, resynchronising a partial block.
    always_comb begin
        row_c   = in_sob ? '0 : wr_row;
        wr_en_c = in_valid && !full[wr_sel];
    end

    // Gather the 8 coefficients of the current zigzag beat from the read entry.
    always_comb begin
        zz_beat_c = '0;
        for (int j = 0; j < BLOCK_ROWS; j++) begin
            nat_c[j] = zz_nat({rd_beat, ROW_W'(j)});
            zz_beat_c[j*W +: W] = store[rd_sel][nat_c[j][IDX_W-1:ROW_W]][nat_c[j][ROW_W-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            for (int c = 0; c < BLOCK_ROWS; c++) begin
                store[wr_sel][row_c][c] <= in_data[c*W +: W];
            end
        end
        if (full[rd_sel]) begin
            out_data <= zz_beat_c;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full        <= '0;
            sof_tag     <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            wr_row      <= '0;
            rd_beat     <= '0;
            out_valid   <= 1'b0;
            out_sob     <= 1'b0;
            out_eob     <= 1'b0;
            out_sof     <= 1'b0;
            err_framing <= 1'b0;
        end else begin
            out_valid   <= 1'b0;
            out_sob     <= 1'b0;
            out_eob     <= 1'b0;
            out_sof     <= 1'b0;
            err_framing <= 1'b0;

            // Drain: one zigzag beat per cycle while the read entry holds a block.
            if (full[rd_sel]) begin
                out_valid <= 1'b1;
                out_sob   <= (rd_beat == '0);
                out_eob   <= (rd_beat == LAST_ROW);
                out_sof   <= (rd_beat == '0) && sof_tag[rd_sel];
                rd_beat   <= rd_beat + ROW_W'(1);
                if (rd_beat == LAST_ROW) begin
                    full[rd_sel] <= 1'b0;
                    rd_sel       <= ~rd_sel;
                end
            end

            // Fill: a block commits only when eob arrives exactly on row 7.
            if (in_valid) begin
                if (in_sob && !full[wr_sel]) begin
                    sof_tag[wr_sel] <= in_sof;
                end
                if (in_eob && row_c == LAST_ROW) begin
                    full[wr_sel] <= 1'b1;
                    wr_sel       <= ~wr_sel;
                    wr_row       <= '0;
                end else if (in_eob || row_c == LAST_ROW) begin
                    err_framing <= 1'b1;
                    wr_row      <= '0;
                end else begin
                    wr_row <= row_c + ROW_W'(1);
                end
            end
        end
    end

endmodule

// File: doc/zigzag_reorder.md
ZIGZAG_REORDER -- requirements
Module: zigzag_reorder

Interface
REQ-001 SHALL have parameter W, default 16: coefficient width in bits.
REQ-002 SHALL have port clk, input, 1: sole clock; all logic rising-edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1: input row beat valid.
REQ-005 SHALL have port in_data, input, 8xW packed: one 8x8-block row, lane j = column j.
REQ-006 SHALL have ports in_sob / in_eob / in_sof, input, 1 each: start of block, end of block, start of frame; qualified by in_valid.
REQ-007 SHALL have port out_valid, output, 1: output beat valid.
REQ-008 SHALL have port out_data, output, 8xW packed: 8 consecutive zigzag-ordered coefficients, lane 0 = lowest zigzag index.
REQ-009 SHALL have ports out_sob / out_eob / out_sof, output, 1 each: framing of the output beat.
REQ-010 SHALL have port err_framing, output, 1: one-cycle pulse on a malformed input block.

Function
REQ-011 SHALL hold a two-entry ping-pong store of 8x8xW blocks: write select wr_sel, read select rd_sel, per-entry full flag.
REQ-012 SHALL keep a 3-bit write row counter; each in_valid beat writes in_data to store[wr_sel][counter], and the counter increments.
REQ-013 SHALL, on in_valid with in_sob, write the beat to row 0 regardless of the counter, set the counter to 1, and capture in_sof as the block's sof tag.
REQ-014 SHALL, on in_valid with in_eob at row 7, mark store[wr_sel] full, toggle wr_sel, and clear the counter.
REQ-015 SHALL, on in_valid with in_eob at row other than 7, pulse err_framing the next cycle, discard the block (no full flag, wr_sel unchanged), and clear the counter.
REQ-016 SHALL, on in_valid at row 7 without in_eob, pulse err_framing, discard the block, and wrap the counter to 0.
REQ-017 SHALL start output the cycle after the completing in_eob beat when the output is idle; latency = 1 cycle.
REQ-018 SHALL emit 8 consecutive out_valid beats k = 0..7; out_data lane j = coefficient at zigzag index 8k+j (standard JPEG zigzag, row-major natural index).
REQ-019 SHALL assert out_sob only on k=0, out_eob only on k=7, and out_sof on k=0 only when the block's sof tag is set; all framing outputs are 0 when out_valid is 0.
REQ-020 SHALL, after k=7, clear the full flag of store[rd_sel] and toggle rd_sel; if the other entry is full, the next block follows with no idle cycle.
REQ-021 SHALL allow a write to the entry being drained only after its full flag clears; with no backpressure, in-order 8-beat blocks never collide.
REQ-022 SHALL pass coefficients unmodified; no arithmetic on data.

Reset
REQ-023 SHALL, on rst_n low at a clock edge, clear out_valid, out_sob, out_eob, out_sof, err_framing, both full flags, wr_sel, rd_sel, the row counter and the output beat counter; store contents need no reset.
REQ-024 SHALL, on reset mid-block, drop the partial input block and any in-flight output block; the first beat after reset release starts a fresh block.

Structure
REQ-025 SHALL take the 64-entry zigzag-to-natural index table (6-bit entries) and the block-rows constant (8) from the shared jpeg package.
REQ-026 SHALL be implemented as a single module with no sub-module; the zigzag mapping is a combinational read mux driven by the package table.

Verification
REQ-027 SHALL cover single block with data(r,c) = 8r+c, rows 0..7, sob on r0, eob on r7 -> out beats 1..8 cycles later; beat 0 = 0,1,8,16,9,2,3,10; beat 7 = 53,60,61,54,47,55,62,63.
REQ-028 SHALL cover two back-to-back blocks (B0 data base 0, B1 base 100) -> 16 consecutive out_valid beats, with no gap, with B1 beat 0 = 100,101,108,116,109,102,103,110.
REQ-029 SHALL cover in_eob on row 4 -> err_framing pulses once, no output block, and the next correct block is output normally.
REQ-030 SHALL cover in_sof=1 on sob of block 0 and in_sof=0 on block 1 -> out_sof=1 only on block 0 beat 0.
REQ-031 SHALL cover rst_n low for 1 cycle during output beat 3 -> all outputs 0 the next cycle, and a subsequent block outputs from beat 0.
REQ-032 SHALL cover in_sob at row 5 of a partial block -> that beat becomes row 0, and after 7 more rows with eob, a correct block is output and err_framing stays 0.
